// File: rtl/spi_pkg.sv
// Shared definitions for the burst SPI slave: bus event codes, FSM states
// and SPI mode decoding.
package spi_pkg;

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_WR   = 2'b01;
  localparam logic [1:0] EV_RD   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Clock polarity: idle level of the SPI clock.
  function automatic logic mode_cpol(input int unsigned mode);
    return ((mode >> 1) & 1) != 0;
  endfunction

  // Clock phase: 0 samples on the leading edge, 1 on the trailing edge.
  function automatic logic mode_cpha(input int unsigned mode);
    return (mode & 1) != 0;
  endfunction

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input int unsigned mode);
    return mode_cpol(mode) == mode_cpha(mode);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall detection
// on the synchronised level (one extra register stage).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sr_q;

  // Stages 0/1 synchronise, stage 2 holds the previous synchronised level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= {3{RST_VAL}};
    end else begin
      sr_q <= {sr_q[1:0], d_i};
    end
  end

  assign q_o    = sr_q[1];
  assign rise_o = sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_burst_slave.sv
// Oversampled SPI slave: one command word (R/W + address) followed by any
// number of data words, bridged onto a strobe-based register bus.
module spi_burst_slave
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SPI_MODE = 0,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_clk_i,
  input  logic              spi_ncs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic [ADDR_W-1:0] b_addr_o,
  input  logic [DATA_W-1:0] b_data_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic [1:0]        b_event_o
);

  localparam logic        CPOL        = mode_cpol(SPI_MODE);
  localparam logic        CPHA        = mode_cpha(SPI_MODE);
  localparam logic        SAMPLE_RISE = sample_on_rise(SPI_MODE);
  localparam int unsigned MAX_W       = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int unsigned RX_W        = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam int unsigned CNT_W       = $clog2(MAX_W + 1);

  // Synchronised pins and edges
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ncs_rise, ncs_fall, ncs_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // SPI clock idles at CPOL so reset does not fabricate an edge.
  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_clk_i),
    .q_o    (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // ncs resets low: a frame already in progress at reset release produces
  // no falling edge, so it is ignored until ncs goes high and low again.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_ncs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_ncs_i),
    .q_o    (ncs_lvl_unused),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_mosi_i),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  // State
  state_t              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [RX_W-1:0]     rx_q;
  logic [DATA_W-1:0]   tx_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic                rd_cap_q;
  logic                miso_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          ev_q;

  // Next-value helpers
  logic                sample_edge_d;
  logic                shift_edge_d;
  logic [RX_W-1:0]     rx_d;
  logic [ADDR_W:0]     cmd_d;
  logic [DATA_W-1:0]   word_d;
  logic [ADDR_W-1:0]   addr_next_d;
  logic                cmd_last_d;
  logic                word_last_d;

  // Edge selection, assembled words and address advance.
  always_comb begin
    sample_edge_d = SAMPLE_RISE ? sclk_rise : sclk_fall;
    shift_edge_d  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    rx_d          = {rx_q[RX_W-2:0], mosi_s};
    cmd_d         = {rx_q[ADDR_W-1:0], mosi_s};
    word_d        = {rx_q[DATA_W-2:0], mosi_s};
    addr_next_d   = (AUTO_INC != 0) ? cur_addr_q + ADDR_W'(1) : cur_addr_q;
    cmd_last_d    = (bit_cnt_q == CNT_W'(ADDR_W));
    word_last_d   = (bit_cnt_q == CNT_W'(DATA_W - 1));
  end

  // Frame FSM with shift registers, counters and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      cur_addr_q <= '0;
      rd_cap_q   <= 1'b0;
      miso_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ev_q       <= EV_NONE;
    end else begin
      ev_q     <= EV_NONE;
      rd_cap_q <= (ev_q == EV_RD);

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          miso_q    <= 1'b0;
          if (ncs_fall) begin
            state_q <= CMD;
          end
        end

        CMD: begin
          if (ncs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
          end else if (sample_edge_d) begin
            rx_q <= rx_d;
            if (cmd_last_d) begin
              bit_cnt_q  <= '0;
              rw_q       <= cmd_d[ADDR_W];
              cur_addr_q <= cmd_d[ADDR_W-1:0];
              state_q    <= DATA;
              if (cmd_d[ADDR_W]) begin
                addr_q <= cmd_d[ADDR_W-1:0];
                ev_q   <= EV_RD;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end

        DATA: begin
          if (ncs_rise) begin
            // Partial word is dropped; no event for it.
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
          end else begin
            if (sample_edge_d) begin
              rx_q <= rx_d;
              if (word_last_d) begin
                bit_cnt_q <= '0;
                if (rw_q) begin
                  cur_addr_q <= addr_next_d;
                  addr_q     <= addr_next_d;
                  ev_q       <= EV_RD;
                end else begin
                  addr_q     <= cur_addr_q;
                  wdata_q    <= word_d;
                  cur_addr_q <= addr_next_d;
                  ev_q       <= EV_WR;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end

            if (rw_q) begin
              if (rd_cap_q) begin
                if (CPHA) begin
                  tx_q <= b_data_i;
                end else begin
                  // MSB goes out at load; the shift edge right after the
                  // word boundary (bit count 0) is skipped below.
                  miso_q <= b_data_i[DATA_W-1];
                  tx_q   <= {b_data_i[DATA_W-2:0], 1'b0};
                end
              end else if (shift_edge_d && (CPHA || (bit_cnt_q != '0))) begin
                miso_q <= tx_q[DATA_W-1];
                tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_miso_o = miso_q;
  assign b_addr_o   = addr_q;
  assign b_data_o   = wdata_q;
  assign b_event_o  = ev_q;

endmodule

// File: tb/tb_spi_burst_slave.sv
// Self-checking bench: a mode-0 and a mode-3 slave driven by a bit-banged
// master, with bus events checked against a queue of expected events.
module tb_spi_burst_slave;

  localparam int H = 100;  // SPI half period (10 system clocks)

  typedef struct {
    logic [1:0] ev;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk0 = 1'b0, ncs0 = 1'b1;
  logic       sclk3 = 1'b1, ncs3 = 1'b1;
  logic       mosi = 1'b0;
  logic       miso0, miso3;
  logic [6:0] addr0, addr3;
  logic [7:0] bdi0 = 8'h00;
  logic [7:0] bdi3;
  logic [7:0] dout0, dout3;
  logic [1:0] ev0, ev3;

  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  assign bdi3 = {1'b0, addr3} ^ 8'hFF;

  always #5 clk = ~clk;

  spi_burst_slave #(.ADDR_W(7), .DATA_W(8), .SPI_MODE(0), .AUTO_INC(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .spi_clk_i(sclk0), .spi_ncs_i(ncs0),
    .spi_mosi_i(mosi), .spi_miso_o(miso0), .b_addr_o(addr0),
    .b_data_i(bdi0), .b_data_o(dout0), .b_event_o(ev0)
  );

  spi_burst_slave #(.ADDR_W(7), .DATA_W(8), .SPI_MODE(3), .AUTO_INC(1)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .spi_clk_i(sclk3), .spi_ncs_i(ncs3),
    .spi_mosi_i(mosi), .spi_miso_o(miso3), .b_addr_o(addr3),
    .b_data_i(bdi3), .b_data_o(dout3), .b_event_o(ev3)
  );

  // Scoreboard for the mode-0 slave
  always @(negedge clk) begin
    if (rst_n && ev0 !== 2'b00) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL ev0_unexpected got ev=%b addr=%h data=%h, required no event", ev0, addr0, dout0);
      end else begin
        e0 = q0.pop_front();
        if (ev0 !== e0.ev || addr0 !== e0.addr || (e0.ev == 2'b01 && dout0 !== e0.data)) begin
          bad++;
          $display("FAIL ev0_match got ev=%b addr=%h data=%h, required ev=%b addr=%h data=%h",
                   ev0, addr0, dout0, e0.ev, e0.addr, e0.data);
        end
      end
    end
  end

  // Scoreboard for the mode-3 slave
  always @(negedge clk) begin
    if (rst_n && ev3 !== 2'b00) begin
      total++;
      if (q3.size() == 0) begin
        bad++;
        $display("FAIL ev3_unexpected got ev=%b addr=%h, required no event", ev3, addr3);
      end else begin
        e3 = q3.pop_front();
        if (ev3 !== e3.ev || addr3 !== e3.addr || (e3.ev == 2'b01 && dout3 !== e3.data)) begin
          bad++;
          $display("FAIL ev3_match got ev=%b addr=%h data=%h, required ev=%b addr=%h data=%h",
                   ev3, addr3, dout3, e3.ev, e3.addr, e3.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push0(input logic [1:0] ev, input logic [6:0] a, input logic [7:0] d);
    exp_t x;
    x.ev = ev; x.addr = a; x.data = d;
    q0.push_back(x);
  endtask

  task automatic push3(input logic [1:0] ev, input logic [6:0] a, input logic [7:0] d);
    exp_t x;
    x.ev = ev; x.addr = a; x.data = d;
    q3.push_back(x);
  endtask

  // Master transfer of nbits, MSB first; returns what was seen on MISO.
  task automatic spi_word(input int m, input int nbits, input logic [7:0] dout,
                          output logic [7:0] din);
    logic [7:0] v;
    v = dout;
    din = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (m == 0) begin
        mosi = v[i];
        #(H);
        din = {din[6:0], miso0};
        sclk0 = 1'b1;
        #(H);
        sclk0 = 1'b0;
      end else begin
        sclk3 = 1'b0;
        mosi = v[i];
        #(H);
        din = {din[6:0], miso3};
        sclk3 = 1'b1;
        #(H);
      end
    end
  endtask

  task automatic frame_begin(input int m);
    if (m == 0) ncs0 = 1'b0; else ncs3 = 1'b0;
    #60;
  endtask

  task automatic frame_end(input int m);
    #60;
    if (m == 0) ncs0 = 1'b1; else ncs3 = 1'b1;
    #300;
  endtask

  // Expected events must all have appeared within the post-frame wait.
  task automatic check_drained(input string name);
    total++;
    if (q0.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL %s_drained got pending q0=%0d q3=%0d, required 0 0", name, q0.size(), q3.size());
      q0.delete();
      q3.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #40;
    total += 4;
    if (miso0 !== 1'b0) begin bad++; $display("FAIL reset_miso0 got %b required 0", miso0); end
    if (addr0 !== 7'h00) begin bad++; $display("FAIL reset_addr0 got %h required 00", addr0); end
    if (dout0 !== 8'h00) begin bad++; $display("FAIL reset_data0 got %h required 00", dout0); end
    if (ev0 !== 2'b00) begin bad++; $display("FAIL reset_ev0 got %b required 00", ev0); end
    rst_n = 1'b1;
    #100;
    total += 3;
    if (miso3 !== 1'b0) begin bad++; $display("FAIL reset_miso3 got %b required 0", miso3); end
    if (addr3 !== 7'h00) begin bad++; $display("FAIL reset_addr3 got %h required 00", addr3); end
    if (ev3 !== 2'b00) begin bad++; $display("FAIL reset_ev3 got %b required 00", ev3); end
  endtask

  task automatic test_write_single();
    logic [7:0] rx;
    frame_begin(0);
    spi_word(0, 8, 8'h25, rx);
    push0(2'b01, 7'h25, 8'h22);
    spi_word(0, 8, 8'h22, rx);
    total++;
    if (rx !== 8'h00) begin bad++; $display("FAIL wr_miso got %h required 00", rx); end
    frame_end(0);
    check_drained("write_single");
  endtask

  task automatic test_read_single();
    logic [7:0] rx;
    bdi0 = 8'hA5;
    frame_begin(0);
    push0(2'b10, 7'h00, 8'h00);
    spi_word(0, 8, 8'h80, rx);
    total++;
    if (rx !== 8'h00) begin bad++; $display("FAIL rd_cmd_miso got %h required 00", rx); end
    push0(2'b10, 7'h01, 8'h00);
    spi_word(0, 8, 8'h00, rx);
    total++;
    if (rx !== 8'hA5) begin bad++; $display("FAIL rd_miso got %h required a5", rx); end
    frame_end(0);
    check_drained("read_single");
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx;
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    frame_begin(0);
    spi_word(0, 8, 8'h7E, rx);
    for (int i = 0; i < 3; i++) begin
      push0(2'b01, 7'(7'h7E + i), d[i]);
      spi_word(0, 8, d[i], rx);
    end
    frame_end(0);
    check_drained("burst_wrap");
  endtask

  task automatic test_mode3_read();
    logic [7:0] rx;
    frame_begin(3);
    push3(2'b10, 7'h10, 8'h00);
    spi_word(3, 8, 8'h90, rx);
    push3(2'b10, 7'h11, 8'h00);
    spi_word(3, 8, 8'h00, rx);
    total++;
    if (rx !== 8'hEF) begin bad++; $display("FAIL m3_word0 got %h required ef", rx); end
    push3(2'b10, 7'h12, 8'h00);
    spi_word(3, 8, 8'h00, rx);
    total++;
    if (rx !== 8'hEE) begin bad++; $display("FAIL m3_word1 got %h required ee", rx); end
    frame_end(3);
    check_drained("mode3_read");
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    frame_begin(0);
    spi_word(0, 8, 8'h05, rx);
    spi_word(0, 5, 8'h1F, rx);
    frame_end(0);
    check_drained("abort");
    total += 2;
    if (addr0 !== 7'h00) begin bad++; $display("FAIL abort_addr_held got %h required 00", addr0); end
    if (dout0 !== 8'h33) begin bad++; $display("FAIL abort_data_held got %h required 33", dout0); end
    frame_begin(0);
    spi_word(0, 8, 8'h33, rx);
    push0(2'b01, 7'h33, 8'h5A);
    spi_word(0, 8, 8'h5A, rx);
    frame_end(0);
    check_drained("after_abort");
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    total += 2;
    if (addr0 !== 7'h33) begin bad++; $display("FAIL pre_rst_addr got %h required 33", addr0); end
    if (dout0 !== 8'h5A) begin bad++; $display("FAIL pre_rst_data got %h required 5a", dout0); end
    frame_begin(0);
    spi_word(0, 8, 8'h40, rx);
    spi_word(0, 4, 8'h0C, rx);
    rst_n = 1'b0;
    #1;
    total += 4;
    if (addr0 !== 7'h00) begin bad++; $display("FAIL rst_mid_addr got %h required 00", addr0); end
    if (dout0 !== 8'h00) begin bad++; $display("FAIL rst_mid_data got %h required 00", dout0); end
    if (ev0 !== 2'b00) begin bad++; $display("FAIL rst_mid_ev got %b required 00", ev0); end
    if (miso0 !== 1'b0) begin bad++; $display("FAIL rst_mid_miso got %b required 0", miso0); end
    #19;
    rst_n = 1'b1;
    // Rest of the interrupted frame must be ignored.
    spi_word(0, 4, 8'h0C, rx);
    spi_word(0, 8, 8'h77, rx);
    frame_end(0);
    check_drained("rst_ignored");
    frame_begin(0);
    spi_word(0, 8, 8'h12, rx);
    push0(2'b01, 7'h12, 8'h99);
    spi_word(0, 8, 8'h99, rx);
    frame_end(0);
    check_drained("after_rst");
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_single();
    test_burst_wrap();
    test_mode3_read();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
